// File: rtl/npc_arb_pkg.sv
// rtl/npc_arb_pkg.sv - shared state encoding and width helper for the memory port arbiter
package npc_arb_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } arb_state_e;

  // Never returns less than 1 so a degenerate count still yields a legal vector.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/MuxKey.sv
// rtl/MuxKey.sv - keyed field selector for the address/data steering muxes
module MuxKey #(
  parameter int NR_KEY   = 2,
  parameter int KEY_LEN  = 1,
  parameter int DATA_LEN = 1
) (
  output logic [DATA_LEN-1:0]        out,
  input  logic [KEY_LEN-1:0]         key,
  input  logic [NR_KEY*DATA_LEN-1:0] lut
);

  always_comb begin
    out = '0;
    for (int i = 0; i < NR_KEY; i++) begin
      if (key == KEY_LEN'(i)) out = lut[i*DATA_LEN +: DATA_LEN];
    end
  end

endmodule

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - round-robin pick: rotate by rr_ptr, priority encode, un-rotate
module rr_picker #(
  parameter int NR_REQ = 2,
  parameter int ID_W   = 1
) (
  input  logic [NR_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]   rr_ptr,
  output logic              hit,
  output logic [ID_W-1:0]   idx
);

  localparam int SUM_W = ID_W + 1;

  logic [NR_REQ-1:0] rotated;
  logic [ID_W-1:0]   offset;
  logic [SUM_W-1:0]  sum;

  always_comb begin
    rotated = NR_REQ'({req_valid, req_valid} >> rr_ptr);
    hit     = |req_valid;
    offset  = '0;
    for (int i = NR_REQ - 1; i >= 0; i--) begin
      if (rotated[i]) offset = ID_W'(i);
    end
    // Wrap modulo NR_REQ explicitly so non-power-of-two counts work.
    sum = {1'b0, offset} + {1'b0, rr_ptr};
    if (sum >= SUM_W'(NR_REQ)) idx = ID_W'(sum - SUM_W'(NR_REQ));
    else                       idx = sum[ID_W-1:0];
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one memory port, with response timeout
module mem_arbiter
  import npc_arb_pkg::*;
#(
  parameter int NR_REQ  = 2,
  parameter int ID_W    = 1,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NR_REQ-1:0]            req_valid,
  output logic [NR_REQ-1:0]            req_ready,
  input  logic [NR_REQ*ADDR_W-1:0]     req_addr,
  input  logic [NR_REQ-1:0]            req_wen,
  input  logic [NR_REQ*DATA_W-1:0]     req_wdata,
  input  logic [NR_REQ*(DATA_W/8)-1:0] req_wmask,
  output logic [NR_REQ-1:0]            resp_valid,
  output logic                         resp_err,
  output logic [DATA_W-1:0]            resp_rdata,
  output logic                         mem_req_valid,
  input  logic                         mem_req_ready,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic                         mem_wen,
  output logic [DATA_W-1:0]            mem_wdata,
  output logic [DATA_W/8-1:0]          mem_wmask,
  input  logic                         mem_resp_valid,
  input  logic [DATA_W-1:0]            mem_resp_rdata,
  output logic [ID_W-1:0]              grant_id,
  output logic                         busy
);

  localparam int MASK_W = DATA_W / 8;
  localparam int CNT_W  = clog2(TIMEOUT + 1);
  // Counter starts at 0 on the first WAIT cycle, so the abort fires at TIMEOUT-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  arb_state_e        state, state_nxt;
  logic [ID_W-1:0]   rr_ptr, rr_ptr_nxt, grant_nxt, ptr_after_grant;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              pick_hit;
  logic [ID_W-1:0]   pick_idx;
  logic              grant_valid;
  logic [NR_REQ-1:0] grant_onehot;

  rr_picker #(.NR_REQ(NR_REQ), .ID_W(ID_W)) u_picker (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .hit       (pick_hit),
    .idx       (pick_idx)
  );

  MuxKey #(.NR_KEY(NR_REQ), .KEY_LEN(ID_W), .DATA_LEN(1)) u_mux_valid (
    .out (grant_valid), .key (grant_id), .lut (req_valid));
  MuxKey #(.NR_KEY(NR_REQ), .KEY_LEN(ID_W), .DATA_LEN(ADDR_W)) u_mux_addr (
    .out (mem_addr), .key (grant_id), .lut (req_addr));
  MuxKey #(.NR_KEY(NR_REQ), .KEY_LEN(ID_W), .DATA_LEN(1)) u_mux_wen (
    .out (mem_wen), .key (grant_id), .lut (req_wen));
  MuxKey #(.NR_KEY(NR_REQ), .KEY_LEN(ID_W), .DATA_LEN(DATA_W)) u_mux_wdata (
    .out (mem_wdata), .key (grant_id), .lut (req_wdata));
  MuxKey #(.NR_KEY(NR_REQ), .KEY_LEN(ID_W), .DATA_LEN(MASK_W)) u_mux_wmask (
    .out (mem_wmask), .key (grant_id), .lut (req_wmask));

  always_comb begin
    for (int i = 0; i < NR_REQ; i++) grant_onehot[i] = (grant_id == ID_W'(i));
    ptr_after_grant = (grant_id == ID_W'(NR_REQ - 1)) ? '0 : grant_id + ID_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      cnt      <= '0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_ptr_nxt;
      grant_id <= grant_nxt;
      cnt      <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    rr_ptr_nxt    = rr_ptr;
    grant_nxt     = grant_id;
    cnt_nxt       = cnt;
    req_ready     = '0;
    resp_valid    = '0;
    resp_err      = 1'b0;
    resp_rdata    = '0;
    mem_req_valid = 1'b0;
    case (state)
      IDLE: begin
        if (pick_hit) begin
          grant_nxt = pick_idx;
          state_nxt = REQ;
        end
      end
      REQ: begin
        mem_req_valid = grant_valid;
        req_ready     = grant_onehot & {NR_REQ{mem_req_ready}};
        // A requester withdrawing before the handshake forfeits its turn slot-wise.
        if (!grant_valid) begin
          state_nxt = IDLE;
        end else if (mem_req_ready) begin
          state_nxt = WAIT;
          cnt_nxt   = '0;
        end
      end
      WAIT: begin
        cnt_nxt = cnt + CNT_W'(1);
        if (mem_resp_valid) begin
          resp_valid = grant_onehot;
          resp_rdata = mem_resp_rdata;
          state_nxt  = IDLE;
          rr_ptr_nxt = ptr_after_grant;
        end else if (TIMEOUT != 0 && cnt == CNT_LAST) begin
          resp_valid = grant_onehot;
          resp_err   = 1'b1;
          state_nxt  = IDLE;
          rr_ptr_nxt = ptr_after_grant;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Round-robin arbiter that shares one memory port between NR_REQ requesters, e.g. IFU (id 0) and LSU (id 1) in the NPC core.
- Grants one requester at a time and holds the grant for a full request/response transaction.
- Drives `grant_id` as the select key for the address/data steering muxes.
- Adds a response timeout so a dead slave cannot hang the core.

Parameters:
- NR_REQ, 2, number of requesters (2..8)
- ID_W, 1, grant index width, equal to clog2(NR_REQ)
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 255, max cycles spent in WAIT before forced abort; 0 disables the timeout

Ports:
- clk  in  1  clock
- rst  in  1  async active-high reset
- req_valid  in  NR_REQ  per-requester request valid
- req_ready  out  NR_REQ  per-requester request accepted
- req_addr  in  NR_REQ*ADDR_W  flattened, slot n at [ADDR_W*(n+1)-1:ADDR_W*n]
- req_wen  in  NR_REQ  write enable per requester
- req_wdata  in  NR_REQ*DATA_W  flattened write data
- req_wmask  in  NR_REQ*(DATA_W/8)  flattened byte mask
- resp_valid  out  NR_REQ  per-requester response pulse
- resp_err  out  1  qualifies resp_valid; high means timeout abort
- resp_rdata  out  DATA_W  read data, broadcast to all requesters
- mem_req_valid  out  1  downstream request valid
- mem_req_ready  in  1  downstream accept
- mem_addr  out  ADDR_W  steered address
- mem_wen  out  1  steered write enable
- mem_wdata  out  DATA_W  steered write data
- mem_wmask  out  DATA_W/8  steered byte mask
- mem_resp_valid  in  1  downstream response
- mem_resp_rdata  in  DATA_W  downstream read data
- grant_id  out  ID_W  current grant index (mux key)
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset values:
  - state=IDLE, rr_ptr=0, grant_id=0, timeout counter=0.
  - All valid/ready outputs 0, resp_err=0, busy=0.
  - Steered outputs reflect requester 0's fields while mem_req_valid=0.
- States: IDLE, REQ, WAIT.
- IDLE:
  - If any req_valid bit is set, pick the first set index scanning rr_ptr, rr_ptr+1, … with wrap mod NR_REQ.
  - Register the pick into grant_id and move to REQ next cycle. Arbitration costs 1 cycle.
  - req_ready=0 and mem_req_valid=0 while in IDLE.
- REQ:
  - mem_req_valid = req_valid[grant_id].
  - mem_addr, mem_wen, mem_wdata and mem_wmask are combinationally steered from slot grant_id.
  - req_ready[grant_id] = mem_req_ready; all other req_ready bits are 0.
  - On mem_req_valid && mem_req_ready: go to WAIT and clear the counter.
  - If req_valid[grant_id] drops before the handshake (protocol violation): return to IDLE, rr_ptr unchanged.
- WAIT:
  - mem_req_valid=0; the counter increments each cycle.
  - On mem_resp_valid: resp_valid[grant_id]=1 for that same cycle (combinational pass), resp_rdata=mem_resp_rdata, resp_err=0.
  - After the response: go to IDLE and set rr_ptr=(grant_id+1) mod NR_REQ.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT with no response: resp_valid[grant_id]=1, resp_err=1, resp_rdata=0, then go to IDLE and rotate rr_ptr as above.
  - A late response arriving after a timeout is dropped.
- mem_resp_valid outside WAIT is ignored and produces no resp_valid.
- Minimum transaction: IDLE → REQ → WAIT → IDLE, 3 cycles when the slave accepts immediately and responds the next cycle.
- New requests in other slots during REQ/WAIT are held off (ready=0). No preemption, one outstanding transaction.
- rr_ptr wraps from NR_REQ-1 to 0.
- An asynchronous reset mid-transaction aborts immediately to reset values; no response is issued.

Decomposition:
- Package `npc_arb_pkg`: state enum (IDLE/REQ/WAIT), state width constant, clog2 helper.
- Sub-module `rr_picker` (combinational): inputs req_valid and rr_ptr; outputs hit and idx via rotate → priority encode → un-rotate.
- Field steering uses the existing MuxKey library template keyed by grant_id, one instance per field.

Test Plan:
- Single request: req_valid=01, addr0=0x8000_0000, slave ready immediately, rdata=0xDEADBEEF next cycle → mem_addr=0x8000_0000 in REQ; resp_valid=01 with 0xDEADBEEF on cycle 3; rr_ptr=1.
- Contention fairness: req_valid=11 held for 4 transactions → grants in order 0,1,0,1; req_ready never high for the non-granted slot.
- Backpressure: mem_req_ready low for 5 cycles in REQ → mem_req_valid and steered fields stable; req_ready=0 throughout; handshake on cycle 6.
- Write steering: slot 1 wen=1, wdata=0x12345678, wmask=0xC → mem_wen=1, mem_wdata=0x12345678, mem_wmask=0xC, grant_id=1.
- Timeout: TIMEOUT=4, no response → resp_valid=10, resp_err=1 on the 4th WAIT cycle; a late mem_resp_valid is ignored; next grant is to slot 0.
- Reset mid-WAIT: assert rst asynchronously → busy=0, all valids 0, grant_id=0 before the next clock edge; no resp_valid after release.
